exe_stage_fwd: RTL and testbench

Parametrised execute stage for the in-order pipeline, successor to the single-issue EXE stage. Adds MEM/WB operand forwarding, an immediate/shift operand mux, and an iterative HI/LO multiply/divide unit with a stall handshake. Also adds FREEZE/FLUSH control of the EXE/MEM pipeline register. Sits between the ID/EX register and the MEM stage.

---
 rtl/exe_pkg.sv | 42 ++++
 rtl/exe_stage_fwd_muldiv.sv | 157 +++++++++++++++
 rtl/exe_stage_fwd.sv | 169 ++++++++++++++++
 tb/tb_exe_stage_fwd.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared opcode encodings, mul/div FSM states and opcode-class helpers for the
// forwarding execute stage.
package exe_pkg;

  localparam logic [5:0] OpAdd   = 6'h20;
  localparam logic [5:0] OpSub   = 6'h22;
  localparam logic [5:0] OpAnd   = 6'h24;
  localparam logic [5:0] OpOr    = 6'h25;
  localparam logic [5:0] OpXor   = 6'h26;
  localparam logic [5:0] OpNor   = 6'h27;
  localparam logic [5:0] OpSlt   = 6'h2A;
  localparam logic [5:0] OpSltu  = 6'h2B;
  localparam logic [5:0] OpSll   = 6'h00;
  localparam logic [5:0] OpSrl   = 6'h02;
  localparam logic [5:0] OpSra   = 6'h03;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpMfhi  = 6'h10;
  localparam logic [5:0] OpMthi  = 6'h11;
  localparam logic [5:0] OpMflo  = 6'h12;
  localparam logic [5:0] OpMtlo  = 6'h13;
  localparam logic [5:0] OpMult  = 6'h18;
  localparam logic [5:0] OpMultu = 6'h19;
  localparam logic [5:0] OpDiv   = 6'h1A;
  localparam logic [5:0] OpDivu  = 6'h1B;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv
  } md_state_e;

  // Ops that start the iterative unit.
  function automatic logic is_muldiv_op(input logic [5:0] op);
    return op inside {OpMult, OpMultu, OpDiv, OpDivu};
  endfunction

  // Ops that must wait while the iterative unit is busy.
  function automatic logic is_hilo_op(input logic [5:0] op);
    return op inside {OpMfhi, OpMthi, OpMflo, OpMtlo, OpMult, OpMultu, OpDiv, OpDivu};
  endfunction

endpackage

// File: rtl/exe_stage_fwd_muldiv.sv
// Iterative HI/LO unit: fixed-latency multiply and restoring divide, plus
// direct HI/LO writes when idle.
module muldiv_unit
  import exe_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MUL_LAT = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            i_freeze,
  input  logic            i_start,
  input  logic            i_is_div,
  input  logic            i_signed,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  input  logic            i_wr_hi,
  input  logic            i_wr_lo,
  input  logic [XLEN-1:0] i_wr_data,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo,
  output logic            o_busy
);

  localparam int unsigned CntMax = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
  localparam int unsigned CntW   = $clog2(CntMax);

  md_state_e         r_state, w_state_nxt;
  logic [CntW-1:0]   r_cnt, w_cnt_nxt;
  logic [XLEN-1:0]   r_hi, w_hi_nxt;
  logic [XLEN-1:0]   r_lo, w_lo_nxt;
  logic [2*XLEN-1:0] r_prod, w_prod_nxt;
  logic [XLEN-1:0]   r_quo, w_quo_nxt;
  logic [XLEN-1:0]   r_rem, w_rem_nxt;
  logic [XLEN-1:0]   r_dvs, w_dvs_nxt;
  logic [XLEN-1:0]   r_dvd, w_dvd_nxt;
  logic              r_neg_q, w_neg_q_nxt;
  logic              r_neg_r, w_neg_r_nxt;
  logic              r_dz, w_dz_nxt;

  logic [2*XLEN-1:0] w_ext_a, w_ext_b, w_prod;
  logic [XLEN-1:0]   w_mag_a, w_mag_b;
  logic [XLEN:0]     w_rem_sh, w_trial;
  logic [XLEN-1:0]   w_step_q, w_step_r;

  assign w_ext_a = i_signed ? {{XLEN{i_op_a[XLEN-1]}}, i_op_a} : {{XLEN{1'b0}}, i_op_a};
  assign w_ext_b = i_signed ? {{XLEN{i_op_b[XLEN-1]}}, i_op_b} : {{XLEN{1'b0}}, i_op_b};
  assign w_prod  = w_ext_a * w_ext_b;
  assign w_mag_a = (i_signed && i_op_a[XLEN-1]) ? -i_op_a : i_op_a;
  assign w_mag_b = (i_signed && i_op_b[XLEN-1]) ? -i_op_b : i_op_b;

  // One restoring step: shift the next dividend bit into the partial remainder.
  assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
  assign w_trial  = w_rem_sh - {1'b0, r_dvs};
  assign w_step_q = {r_quo[XLEN-2:0], ~w_trial[XLEN]};
  assign w_step_r = w_trial[XLEN] ? w_rem_sh[XLEN-1:0] : w_trial[XLEN-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_prod_nxt  = r_prod;
    w_quo_nxt   = r_quo;
    w_rem_nxt   = r_rem;
    w_dvs_nxt   = r_dvs;
    w_dvd_nxt   = r_dvd;
    w_neg_q_nxt = r_neg_q;
    w_neg_r_nxt = r_neg_r;
    w_dz_nxt    = r_dz;
    if (!i_freeze) begin
      unique case (r_state)
        StIdle: begin
          if (i_start && i_is_div) begin
            w_state_nxt = StDiv;
            w_cnt_nxt   = CntW'(XLEN - 1);
            w_quo_nxt   = w_mag_a;
            w_rem_nxt   = '0;
            w_dvs_nxt   = w_mag_b;
            w_dvd_nxt   = i_op_a;
            w_neg_q_nxt = i_signed & (i_op_a[XLEN-1] ^ i_op_b[XLEN-1]);
            w_neg_r_nxt = i_signed & i_op_a[XLEN-1];
            w_dz_nxt    = (i_op_b == '0);
          end else if (i_start) begin
            w_state_nxt = StMul;
            w_cnt_nxt   = CntW'(MUL_LAT - 1);
            w_prod_nxt  = w_prod;
          end else begin
            if (i_wr_hi) w_hi_nxt = i_wr_data;
            if (i_wr_lo) w_lo_nxt = i_wr_data;
          end
        end
        StMul: begin
          if (r_cnt == '0) begin
            w_state_nxt = StIdle;
            w_hi_nxt    = r_prod[2*XLEN-1:XLEN];
            w_lo_nxt    = r_prod[XLEN-1:0];
          end else begin
            w_cnt_nxt = r_cnt - CntW'(1);
          end
        end
        StDiv: begin
          w_quo_nxt = w_step_q;
          w_rem_nxt = w_step_r;
          if (r_cnt == '0) begin
            w_state_nxt = StIdle;
            if (r_dz) begin
              w_lo_nxt = '1;
              w_hi_nxt = r_dvd;
            end else begin
              w_lo_nxt = r_neg_q ? -w_step_q : w_step_q;
              w_hi_nxt = r_neg_r ? -w_step_r : w_step_r;
            end
          end else begin
            w_cnt_nxt = r_cnt - CntW'(1);
          end
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_prod  <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_dvd   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_prod  <= w_prod_nxt;
      r_quo   <= w_quo_nxt;
      r_rem   <= w_rem_nxt;
      r_dvs   <= w_dvs_nxt;
      r_dvd   <= w_dvd_nxt;
      r_neg_q <= w_neg_q_nxt;
      r_neg_r <= w_neg_r_nxt;
      r_dz    <= w_dz_nxt;
    end
  end

  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
  assign o_busy = (r_state != StIdle);

endmodule

// File: rtl/exe_stage_fwd.sv
// Execute stage with MEM/WB forwarding, immediate/shift operand mux, HI/LO
// mul/div issue with stall handshake, and FREEZE/FLUSH of the EXE/MEM register.
module exe_stage_fwd
  import exe_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned MUL_LAT = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               FREEZE,
  input  logic               FLUSH,
  input  logic               valid_in,
  input  logic [5:0]         ALU_control,
  input  logic               ALUSrc,
  input  logic [XLEN-1:0]    Imm,
  input  logic [4:0]         Instr_10_6,
  input  logic [XLEN-1:0]    Operand_A,
  input  logic [XLEN-1:0]    Operand_B,
  input  logic [RADDR_W-1:0] readRegisterA,
  input  logic [RADDR_W-1:0] readRegisterB,
  input  logic [RADDR_W-1:0] writeRegister,
  input  logic               do_writeback,
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic               MemtoReg,
  input  logic [XLEN-1:0]    Data_MEM,
  input  logic [XLEN-1:0]    Data_WB,
  input  logic [RADDR_W-1:0] writeRegister_MEM,
  input  logic [RADDR_W-1:0] writeRegister_WB,
  input  logic               do_writeback_MEM,
  input  logic               do_writeback_WB,
  output logic               stall_out,
  output logic [XLEN-1:0]    aluResult_PR,
  output logic [XLEN-1:0]    readDataB_PR,
  output logic [RADDR_W-1:0] writeRegister_PR,
  output logic               valid_PR,
  output logic               do_writeback_PR,
  output logic               MemRead_PR,
  output logic               MemWrite_PR,
  output logic               MemtoReg_PR
);

  localparam int unsigned ShW    = $clog2(XLEN);
  localparam logic [4:0]  ShMask = (ShW >= 5) ? 5'h1f : 5'((1 << ShW) - 1);

  logic [XLEN-1:0] w_fwd_a, w_fwd_b, w_op_b, w_alu, w_hi, w_lo;
  logic [4:0]      w_shamt;
  logic            w_busy, w_is_md, w_is_hilo, w_issue_ok, w_bubble;

  logic [XLEN-1:0]    r_alu, r_rdb;
  logic [RADDR_W-1:0] r_wreg;
  logic               r_valid, r_wb, r_mrd, r_mwr, r_m2r;

  // MEM beats WB beats register file; r0 never forwards.
  always_comb begin
    w_fwd_a = Operand_A;
    if (readRegisterA != '0 && do_writeback_MEM && writeRegister_MEM == readRegisterA) begin
      w_fwd_a = Data_MEM;
    end else if (readRegisterA != '0 && do_writeback_WB && writeRegister_WB == readRegisterA) begin
      w_fwd_a = Data_WB;
    end
  end

  always_comb begin
    w_fwd_b = Operand_B;
    if (readRegisterB != '0 && do_writeback_MEM && writeRegister_MEM == readRegisterB) begin
      w_fwd_b = Data_MEM;
    end else if (readRegisterB != '0 && do_writeback_WB && writeRegister_WB == readRegisterB) begin
      w_fwd_b = Data_WB;
    end
  end

  assign w_op_b  = ALUSrc ? Imm : w_fwd_b;
  assign w_shamt = Instr_10_6 & ShMask;

  always_comb begin
    w_alu = '0;
    case (ALU_control)
      OpAdd:          w_alu = w_fwd_a + w_op_b;
      OpSub:          w_alu = w_fwd_a - w_op_b;
      OpAnd:          w_alu = w_fwd_a & w_op_b;
      OpOr:           w_alu = w_fwd_a | w_op_b;
      OpXor:          w_alu = w_fwd_a ^ w_op_b;
      OpNor:          w_alu = ~(w_fwd_a | w_op_b);
      OpSlt:          w_alu = {{(XLEN-1){1'b0}}, ($signed(w_fwd_a) < $signed(w_op_b))};
      OpSltu:         w_alu = {{(XLEN-1){1'b0}}, (w_fwd_a < w_op_b)};
      OpSll:          w_alu = w_op_b << w_shamt;
      OpSrl:          w_alu = w_op_b >> w_shamt;
      OpSra:          w_alu = $unsigned($signed(w_op_b) >>> w_shamt);
      OpLui:          w_alu = Imm << (XLEN / 2);
      OpMfhi:         w_alu = w_hi;
      OpMflo:         w_alu = w_lo;
      OpMthi, OpMtlo: w_alu = w_fwd_a;
      default:        w_alu = '0;
    endcase
  end

  assign w_is_md   = is_muldiv_op(ALU_control);
  assign w_is_hilo = is_hilo_op(ALU_control);
  assign stall_out = valid_in & w_busy & w_is_hilo;
  // HI/LO side effects only for a live, unflushed instruction on an unfrozen cycle.
  assign w_issue_ok = valid_in & ~w_busy & ~FREEZE & ~FLUSH;
  assign w_bubble   = FLUSH | ~valid_in | stall_out | w_is_md;

  muldiv_unit #(
    .XLEN    (XLEN),
    .MUL_LAT (MUL_LAT)
  ) u_muldiv (
    .CLK       (CLK),
    .RESET     (RESET),
    .i_freeze  (FREEZE),
    .i_start   (w_issue_ok & w_is_md),
    .i_is_div  (ALU_control == OpDiv || ALU_control == OpDivu),
    .i_signed  (ALU_control == OpMult || ALU_control == OpDiv),
    .i_op_a    (w_fwd_a),
    .i_op_b    (w_fwd_b),
    .i_wr_hi   (w_issue_ok & (ALU_control == OpMthi)),
    .i_wr_lo   (w_issue_ok & (ALU_control == OpMtlo)),
    .i_wr_data (w_fwd_a),
    .o_hi      (w_hi),
    .o_lo      (w_lo),
    .o_busy    (w_busy)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_alu   <= '0;
      r_rdb   <= '0;
      r_wreg  <= '0;
      r_valid <= 1'b0;
      r_wb    <= 1'b0;
      r_mrd   <= 1'b0;
      r_mwr   <= 1'b0;
      r_m2r   <= 1'b0;
    end else if (!FREEZE) begin
      if (w_bubble) begin
        r_alu   <= '0;
        r_rdb   <= '0;
        r_wreg  <= '0;
        r_valid <= 1'b0;
        r_wb    <= 1'b0;
        r_mrd   <= 1'b0;
        r_mwr   <= 1'b0;
        r_m2r   <= 1'b0;
      end else begin
        r_alu   <= w_alu;
        r_rdb   <= w_fwd_b;
        r_wreg  <= writeRegister;
        r_valid <= 1'b1;
        r_wb    <= do_writeback;
        r_mrd   <= MemRead;
        r_mwr   <= MemWrite;
        r_m2r   <= MemtoReg;
      end
    end
  end

  assign aluResult_PR     = r_alu;
  assign readDataB_PR     = r_rdb;
  assign writeRegister_PR = r_wreg;
  assign valid_PR         = r_valid;
  assign do_writeback_PR  = r_wb;
  assign MemRead_PR       = r_mrd;
  assign MemWrite_PR      = r_mwr;
  assign MemtoReg_PR      = r_m2r;

endmodule

// File: tb/tb_exe_stage_fwd.sv
// Directed bench for exe_stage_fwd: ALU/forwarding vector table plus
// hand-written mul/div, FREEZE, FLUSH and reset sequences.
module tb_exe_stage_fwd;
  import exe_pkg::*;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned RADDR_W = 5;
  localparam int unsigned MUL_LAT = 4;

  logic CLK = 1'b0;
  logic RESET, FREEZE, FLUSH, valid_in, ALUSrc;
  logic [5:0] ALU_control;
  logic [XLEN-1:0] Imm, Operand_A, Operand_B, Data_MEM, Data_WB;
  logic [4:0] Instr_10_6;
  logic [RADDR_W-1:0] readRegisterA, readRegisterB, writeRegister;
  logic [RADDR_W-1:0] writeRegister_MEM, writeRegister_WB;
  logic do_writeback, MemRead, MemWrite, MemtoReg, do_writeback_MEM, do_writeback_WB;
  logic stall_out;
  logic [XLEN-1:0] aluResult_PR, readDataB_PR;
  logic [RADDR_W-1:0] writeRegister_PR;
  logic valid_PR, do_writeback_PR, MemRead_PR, MemWrite_PR, MemtoReg_PR;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  exe_stage_fwd #(
    .XLEN    (XLEN),
    .RADDR_W (RADDR_W),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .FREEZE            (FREEZE),
    .FLUSH             (FLUSH),
    .valid_in          (valid_in),
    .ALU_control       (ALU_control),
    .ALUSrc            (ALUSrc),
    .Imm               (Imm),
    .Instr_10_6        (Instr_10_6),
    .Operand_A         (Operand_A),
    .Operand_B         (Operand_B),
    .readRegisterA     (readRegisterA),
    .readRegisterB     (readRegisterB),
    .writeRegister     (writeRegister),
    .do_writeback      (do_writeback),
    .MemRead           (MemRead),
    .MemWrite          (MemWrite),
    .MemtoReg          (MemtoReg),
    .Data_MEM          (Data_MEM),
    .Data_WB           (Data_WB),
    .writeRegister_MEM (writeRegister_MEM),
    .writeRegister_WB  (writeRegister_WB),
    .do_writeback_MEM  (do_writeback_MEM),
    .do_writeback_WB   (do_writeback_WB),
    .stall_out         (stall_out),
    .aluResult_PR      (aluResult_PR),
    .readDataB_PR      (readDataB_PR),
    .writeRegister_PR  (writeRegister_PR),
    .valid_PR          (valid_PR),
    .do_writeback_PR   (do_writeback_PR),
    .MemRead_PR        (MemRead_PR),
    .MemWrite_PR       (MemWrite_PR),
    .MemtoReg_PR       (MemtoReg_PR)
  );

  typedef struct {
    logic [5:0]  op;
    logic        src;
    logic [31:0] imm;
    logic [4:0]  sh;
    logic [31:0] a, b;
    logic [4:0]  ra, rb;
    logic [31:0] dm, dw;
    logic [4:0]  wm, ww;
    logic        em, ew;
    logic [31:0] exp_res, exp_rdb;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic [5:0] op, input logic src, input logic [31:0] imm,
                              input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] ra, input logic [4:0] rb,
                              input logic [31:0] dm, input logic [31:0] dw,
                              input logic [4:0] wm, input logic [4:0] ww,
                              input logic em, input logic ew,
                              input logic [31:0] er, input logic [31:0] erb);
    vec_t v;
    v.op = op; v.src = src; v.imm = imm; v.sh = sh; v.a = a; v.b = b; v.ra = ra; v.rb = rb;
    v.dm = dm; v.dw = dw; v.wm = wm; v.ww = ww; v.em = em; v.ew = ew;
    v.exp_res = er; v.exp_rdb = erb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_in();
    FREEZE = 0; FLUSH = 0; valid_in = 0; ALU_control = OpSll; ALUSrc = 0; Imm = '0;
    Instr_10_6 = '0; Operand_A = '0; Operand_B = '0; readRegisterA = '0; readRegisterB = '0;
    writeRegister = '0; do_writeback = 0; MemRead = 0; MemWrite = 0; MemtoReg = 0;
    Data_MEM = '0; Data_WB = '0; writeRegister_MEM = '0; writeRegister_WB = '0;
    do_writeback_MEM = 0; do_writeback_WB = 0;
  endtask

  task automatic set_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    clear_in();
    valid_in = 1; ALU_control = op; Operand_A = a; Operand_B = b;
    readRegisterA = 5'd1; readRegisterB = 5'd2; writeRegister = 5'd7; do_writeback = 1;
  endtask

  // Issue an op that should not stall and check its registered result.
  task automatic run_read(input string nm, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] exp);
    @(negedge CLK);
    set_op(op, a, 32'd0);
    #1 chk({nm, " stall"}, {31'd0, stall_out}, 32'd0);
    @(posedge CLK); #1;
    chk({nm, " result"}, aluResult_PR, exp);
  endtask

  task automatic issue(input string nm, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge CLK);
    set_op(op, a, b);
    @(posedge CLK); #1;
    chk({nm, " issue bubble valid"}, {31'd0, valid_PR}, 32'd0);
    chk({nm, " issue bubble wb"}, {31'd0, do_writeback_PR}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel;
    vecs[0]  = mk(OpAdd,  0, 0, 0, 32'd100, 32'd1, 3, 4, 5, 9, 3, 3, 1, 1, 32'd6, 32'd1);
    vecs[1]  = mk(OpAdd,  0, 0, 0, 32'd100, 32'd1, 0, 4, 5, 9, 0, 0, 1, 1, 32'd101, 32'd1);
    vecs[2]  = mk(OpAdd,  0, 0, 0, 32'd100, 32'd2, 3, 4, 5, 9, 3, 3, 0, 1, 32'd11, 32'd2);
    vecs[3]  = mk(OpSub,  0, 0, 0, 32'd10, 32'd99, 1, 2, 3, 50, 2, 2, 1, 1, 32'd7, 32'd3);
    vecs[4]  = mk(OpAdd,  1, 32'h10, 0, 32'd5, 32'd99, 1, 2, 3, 0, 2, 0, 1, 0, 32'h15, 32'd3);
    vecs[5]  = mk(OpAnd,  0, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 1, 2, 0, 0, 0, 0, 0, 0,
                  32'hF000F000, 32'hFF00FF00);
    vecs[6]  = mk(OpOr,   0, 0, 0, 32'hF0F0F0F0, 32'h0F0F0000, 1, 2, 0, 0, 0, 0, 0, 0,
                  32'hFFFFF0F0, 32'h0F0F0000);
    vecs[7]  = mk(OpXor,  0, 0, 0, 32'hFFFF0000, 32'h0F0F0F0F, 1, 2, 0, 0, 0, 0, 0, 0,
                  32'hF0F00F0F, 32'h0F0F0F0F);
    vecs[8]  = mk(OpNor,  0, 0, 0, 32'hF0F0F0F0, 32'h0F0F0000, 1, 2, 0, 0, 0, 0, 0, 0,
                  32'h00000F0F, 32'h0F0F0000);
    vecs[9]  = mk(OpSlt,  0, 0, 0, 32'hFFFFFFFF, 32'd1, 1, 2, 0, 0, 0, 0, 0, 0, 32'd1, 32'd1);
    vecs[10] = mk(OpSltu, 0, 0, 0, 32'hFFFFFFFF, 32'd1, 1, 2, 0, 0, 0, 0, 0, 0, 32'd0, 32'd1);
    vecs[11] = mk(OpSll,  0, 0, 31, 32'd0, 32'd1, 1, 2, 0, 0, 0, 0, 0, 0, 32'h80000000, 32'd1);
    vecs[12] = mk(OpSrl,  0, 0, 4, 32'd0, 32'h80000000, 1, 2, 0, 0, 0, 0, 0, 0,
                  32'h08000000, 32'h80000000);
    vecs[13] = mk(OpSra,  0, 0, 4, 32'd0, 32'h80000000, 1, 2, 0, 0, 0, 0, 0, 0,
                  32'hF8000000, 32'h80000000);
    vecs[14] = mk(OpSub,  0, 0, 0, 32'd0, 32'd1, 1, 2, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 32'd1);
    vecs[15] = mk(OpAdd,  0, 0, 0, 32'hFFFFFFFF, 32'd2, 1, 2, 0, 0, 0, 0, 0, 0, 32'd1, 32'd2);
    vecs[16] = mk(OpLui,  1, 32'h1234, 0, 32'd0, 32'd0, 1, 2, 0, 0, 0, 0, 0, 0,
                  32'h12340000, 32'd0);
    vecs[17] = mk(OpMfhi, 0, 0, 0, 32'd0, 32'd0, 1, 2, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0);

    RESET = 0;
    clear_in();
    #1;
    chk("reset valid_PR", {31'd0, valid_PR}, 32'd0);
    chk("reset aluResult_PR", aluResult_PR, 32'd0);
    chk("reset stall_out", {31'd0, stall_out}, 32'd0);
    @(negedge CLK);
    RESET = 1;

    for (int i = 0; i < 18; i++) begin
      @(negedge CLK);
      clear_in();
      valid_in = 1; writeRegister = 5'd7; do_writeback = 1;
      ALU_control = vecs[i].op; ALUSrc = vecs[i].src; Imm = vecs[i].imm;
      Instr_10_6 = vecs[i].sh; Operand_A = vecs[i].a; Operand_B = vecs[i].b;
      readRegisterA = vecs[i].ra; readRegisterB = vecs[i].rb;
      Data_MEM = vecs[i].dm; Data_WB = vecs[i].dw;
      writeRegister_MEM = vecs[i].wm; writeRegister_WB = vecs[i].ww;
      do_writeback_MEM = vecs[i].em; do_writeback_WB = vecs[i].ew;
      @(posedge CLK); #1;
      chk($sformatf("vec%0d result", i), aluResult_PR, vecs[i].exp_res);
      chk($sformatf("vec%0d readDataB", i), readDataB_PR, vecs[i].exp_rdb);
      chk($sformatf("vec%0d valid", i), {31'd0, valid_PR}, 32'd1);
    end
    chk("vec writeRegister_PR", {27'd0, writeRegister_PR}, 32'd7);

    // MTHI / MTLO then read back.
    @(negedge CLK); set_op(OpMthi, 32'h12345678, 32'd0);
    @(negedge CLK); set_op(OpMtlo, 32'h9ABCDEF0, 32'd0);
    run_read("mthi readback", OpMfhi, 32'd0, 32'h12345678);
    run_read("mtlo readback", OpMflo, 32'd0, 32'h9ABCDEF0);

    // MULT -1 * 2: stall for MUL_LAT cycles, MFHI lands at issue+MUL_LAT+1.
    issue("mult", OpMult, 32'hFFFFFFFF, 32'd2);
    for (int k = 0; k <= MUL_LAT; k++) begin
      @(negedge CLK);
      set_op(OpMfhi, 32'd0, 32'd0);
      #1 chk($sformatf("mult stall k=%0d", k), {31'd0, stall_out}, {31'd0, k < MUL_LAT});
      @(posedge CLK); #1;
      if (k < MUL_LAT) chk($sformatf("mult bubble k=%0d", k), {31'd0, valid_PR}, 32'd0);
    end
    chk("mult mfhi result", aluResult_PR, 32'hFFFFFFFF);
    chk("mult mfhi valid", {31'd0, valid_PR}, 32'd1);
    run_read("mult mflo", OpMflo, 32'd0, 32'hFFFFFFFE);

    // DIV -7/2 with an independent ADD overlapping, then a stalled MFLO.
    issue("div", OpDiv, 32'hFFFFFFF9, 32'd2);
    @(negedge CLK);
    set_op(OpAdd, 32'd3, 32'd4);
    #1 chk("overlap add stall", {31'd0, stall_out}, 32'd0);
    @(posedge CLK); #1;
    chk("overlap add result", aluResult_PR, 32'd7);
    chk("overlap add valid", {31'd0, valid_PR}, 32'd1);
    rel = -1;
    for (int k = 1; k <= XLEN + 4; k++) begin
      @(negedge CLK);
      set_op(OpMflo, 32'd0, 32'd0);
      #1;
      if (!stall_out) begin
        rel = k;
        break;
      end
      @(posedge CLK); #1;
      if (k == 1) chk("div mflo bubble", {31'd0, valid_PR}, 32'd0);
    end
    chk("div stall release cycle", rel, XLEN);
    @(posedge CLK); #1;
    chk("div quotient", aluResult_PR, 32'hFFFFFFFD);
    run_read("div remainder", OpMfhi, 32'd0, 32'hFFFFFFFF);

    // DIVU 7/0.
    issue("divu0", OpDivu, 32'd7, 32'd0);
    for (int k = 0; k < XLEN; k++) begin
      @(negedge CLK); clear_in();
    end
    run_read("divu0 lo", OpMflo, 32'd0, 32'hFFFFFFFF);
    run_read("divu0 hi", OpMfhi, 32'd0, 32'd7);

    // FREEZE for 3 cycles during a MULT: PR held, latency grows by 3.
    issue("frz mult", OpMult, 32'd3, 32'd5);
    @(negedge CLK); set_op(OpAdd, 32'd20, 32'd22);
    @(posedge CLK); #1;
    chk("frz pre result", aluResult_PR, 32'd42);
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK);
      set_op(OpAdd, 32'd1, 32'd1);
      writeRegister = 5'd9; do_writeback = 0; FREEZE = 1;
      @(posedge CLK); #1;
      chk($sformatf("frz hold result k=%0d", k), aluResult_PR, 32'd42);
      chk($sformatf("frz hold wreg k=%0d", k), {27'd0, writeRegister_PR}, 32'd7);
      chk($sformatf("frz hold wb k=%0d", k), {31'd0, do_writeback_PR}, 32'd1);
    end
    for (int k = 4; k <= MUL_LAT + 3; k++) begin
      @(negedge CLK);
      set_op(OpMflo, 32'd0, 32'd0);
      #1 chk($sformatf("frz stall k=%0d", k), {31'd0, stall_out}, {31'd0, k < MUL_LAT + 3});
      @(posedge CLK); #1;
    end
    chk("frz mflo result", aluResult_PR, 32'd15);
    chk("frz mflo valid", {31'd0, valid_PR}, 32'd1);

    // FLUSH of a store, then the same store unflushed, then a load.
    @(negedge CLK);
    set_op(OpAdd, 32'd100, 32'd55);
    ALUSrc = 1; Imm = 32'd4; do_writeback = 0; MemWrite = 1; FLUSH = 1;
    @(posedge CLK); #1;
    chk("flush valid", {31'd0, valid_PR}, 32'd0);
    chk("flush memwrite", {31'd0, MemWrite_PR}, 32'd0);
    @(negedge CLK); FLUSH = 0;
    @(posedge CLK); #1;
    chk("store valid", {31'd0, valid_PR}, 32'd1);
    chk("store memwrite", {31'd0, MemWrite_PR}, 32'd1);
    chk("store addr", aluResult_PR, 32'd104);
    chk("store data", readDataB_PR, 32'd55);
    @(negedge CLK);
    set_op(OpAdd, 32'd8, 32'd0);
    ALUSrc = 1; Imm = 32'd4; MemRead = 1; MemtoReg = 1;
    @(posedge CLK); #1;
    chk("load memread", {31'd0, MemRead_PR}, 32'd1);
    chk("load memtoreg", {31'd0, MemtoReg_PR}, 32'd1);
    chk("load wb", {31'd0, do_writeback_PR}, 32'd1);

    // Asynchronous reset in the middle of a DIV.
    issue("rst div", OpDiv, 32'd100, 32'd3);
    @(negedge CLK); set_op(OpAdd, 32'd1, 32'd1);
    @(posedge CLK); #1;
    chk("rst pre result", aluResult_PR, 32'd2);
    @(negedge CLK);
    set_op(OpMflo, 32'd0, 32'd0);
    #1 chk("rst pre stall", {31'd0, stall_out}, 32'd1);
    #1 RESET = 0;
    #1;
    chk("rst result", aluResult_PR, 32'd0);
    chk("rst valid", {31'd0, valid_PR}, 32'd0);
    chk("rst wb", {31'd0, do_writeback_PR}, 32'd0);
    chk("rst wreg", {27'd0, writeRegister_PR}, 32'd0);
    chk("rst stall", {31'd0, stall_out}, 32'd0);
    @(negedge CLK);
    RESET = 1;
    run_read("rst mfhi", OpMfhi, 32'd0, 32'd0);
    run_read("rst mflo", OpMflo, 32'd0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
